// File: rtl/score_keeper.sv
// score_keeper: game score counter with BCD digits, saturation, penalty floor,
// and a session high score with new-record flag. All event inputs are
// rising-edge detected; the detected events are registered before use.
module score_keeper #(
  parameter int MAX_SCORE = 99,
  parameter int PENALTY   = 1
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Start,
  input  logic       i_Point,
  input  logic       i_Penalty,
  input  logic       i_Game_Over,
  output logic [6:0] o_Score,
  output logic [3:0] o_Tens,
  output logic [3:0] o_Ones,
  output logic [6:0] o_High_Score,
  output logic       o_New_High,
  output logic       o_Playing
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam logic [6:0] MAX_S    = 7'(MAX_SCORE);
  localparam logic [6:0] PEN_S    = 7'(PENALTY);
  // Penalty split into BCD digits at elaboration time
  localparam logic [3:0] PEN_ONES = 4'(PENALTY % 10);
  localparam logic [3:0] PEN_TENS = 4'(PENALTY / 10);

  logic   start_q_r, point_q_r, penalty_q_r, over_q_r;
  logic   start_ev_r, point_ev_r, penalty_ev_r, over_ev_r;
  state_t state_r, state_nx_s;
  logic [6:0] score_r, score_nx_s;
  logic [3:0] tens_r, tens_nx_s;
  logic [3:0] ones_r, ones_nx_s;
  logic [6:0] high_r, high_nx_s;
  logic       new_high_r, new_high_nx_s;
  logic       playing_r;

  // Input history and registered rising-edge events
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      start_q_r    <= 1'b0;
      point_q_r    <= 1'b0;
      penalty_q_r  <= 1'b0;
      over_q_r     <= 1'b0;
      start_ev_r   <= 1'b0;
      point_ev_r   <= 1'b0;
      penalty_ev_r <= 1'b0;
      over_ev_r    <= 1'b0;
    end else begin
      start_q_r    <= i_Start;
      point_q_r    <= i_Point;
      penalty_q_r  <= i_Penalty;
      over_q_r     <= i_Game_Over;
      start_ev_r   <= i_Start & ~start_q_r;
      point_ev_r   <= i_Point & ~point_q_r;
      penalty_ev_r <= i_Penalty & ~penalty_q_r;
      over_ev_r    <= i_Game_Over & ~over_q_r;
    end
  end

  // Next state, next score (incremental BCD with carry/borrow) and high score
  always_comb begin
    state_nx_s    = state_r;
    score_nx_s    = score_r;
    tens_nx_s     = tens_r;
    ones_nx_s     = ones_r;
    high_nx_s     = high_r;
    new_high_nx_s = new_high_r;
    case (state_r)
      IDLE, OVER: begin
        if (start_ev_r) begin
          state_nx_s    = PLAY;
          score_nx_s    = 7'd0;
          tens_nx_s     = 4'd0;
          ones_nx_s     = 4'd0;
          new_high_nx_s = 1'b0;
        end else begin
          state_nx_s = state_r;
        end
      end
      PLAY: begin
        if (point_ev_r && !penalty_ev_r) begin
          if (score_r < MAX_S) begin
            score_nx_s = score_r + 7'd1;
            if (ones_r == 4'd9) begin
              ones_nx_s = 4'd0;
              tens_nx_s = tens_r + 4'd1;
            end else begin
              ones_nx_s = ones_r + 4'd1;
              tens_nx_s = tens_r;
            end
          end else begin
            score_nx_s = score_r;
          end
        end else if (penalty_ev_r && !point_ev_r) begin
          if (score_r <= PEN_S) begin
            score_nx_s = 7'd0;
            tens_nx_s  = 4'd0;
            ones_nx_s  = 4'd0;
          end else begin
            score_nx_s = score_r - PEN_S;
            if (ones_r >= PEN_ONES) begin
              ones_nx_s = ones_r - PEN_ONES;
              tens_nx_s = tens_r - PEN_TENS;
            end else begin
              // Borrow from the tens digit; modular 4-bit math lands in 0..9
              ones_nx_s = ones_r + 4'd10 - PEN_ONES;
              tens_nx_s = tens_r - PEN_TENS - 4'd1;
            end
          end
        end else begin
          // No event, or point and penalty together: net zero
          score_nx_s = score_r;
        end
        if (score_nx_s > high_r) begin
          high_nx_s     = score_nx_s;
          new_high_nx_s = 1'b1;
        end else begin
          high_nx_s = high_r;
        end
        if (over_ev_r) begin
          state_nx_s = OVER;
        end else begin
          state_nx_s = PLAY;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_r    <= IDLE;
      score_r    <= 7'd0;
      tens_r     <= 4'd0;
      ones_r     <= 4'd0;
      high_r     <= 7'd0;
      new_high_r <= 1'b0;
      playing_r  <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      score_r    <= score_nx_s;
      tens_r     <= tens_nx_s;
      ones_r     <= ones_nx_s;
      high_r     <= high_nx_s;
      new_high_r <= new_high_nx_s;
      playing_r  <= (state_nx_s == PLAY);
    end
  end

  assign o_Score      = score_r;
  assign o_Tens       = tens_r;
  assign o_Ones       = ones_r;
  assign o_High_Score = high_r;
  assign o_New_High   = new_high_r;
  assign o_Playing    = playing_r;

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: stimulus pushes hand-computed
// expectations stamped with the cycle they are due; a negedge monitor pops
// and compares them against the DUT outputs.
module tb_score_keeper;

  logic       i_Clk = 1'b0;
  logic       i_Rst_L, i_Start, i_Point, i_Penalty, i_Game_Over;
  logic [6:0] o_Score, o_High_Score;
  logic [3:0] o_Tens, o_Ones;
  logic       o_New_High, o_Playing;

  score_keeper #(.MAX_SCORE(99), .PENALTY(1)) dut (
    .i_Clk       (i_Clk),
    .i_Rst_L     (i_Rst_L),
    .i_Start     (i_Start),
    .i_Point     (i_Point),
    .i_Penalty   (i_Penalty),
    .i_Game_Over (i_Game_Over),
    .o_Score     (o_Score),
    .o_Tens      (o_Tens),
    .o_Ones      (o_Ones),
    .o_High_Score(o_High_Score),
    .o_New_High  (o_New_High),
    .o_Playing   (o_Playing)
  );

  always #5 i_Clk = ~i_Clk;

  int cyc = 0;
  always @(posedge i_Clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int         stamp;
    logic [6:0] score;
    logic [6:0] high;
    logic       nh;
    logic       play;
    string      name;
  } exp_t;

  exp_t sb_q[$];

  // Current hand-computed expectation
  logic [6:0] c_score = 7'd0, c_high = 7'd0;
  logic       c_nh = 1'b0, c_play = 1'b0;

  task automatic set_cur(input int s, input int h, input logic nh, input logic play);
    c_score = 7'(s);
    c_high  = 7'(h);
    c_nh    = nh;
    c_play  = play;
  endtask

  task automatic push(input int dly, input string name);
    exp_t e;
    e.stamp = cyc + dly;
    e.score = c_score;
    e.high  = c_high;
    e.nh    = c_nh;
    e.play  = c_play;
    e.name  = name;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask

  // mask bits: 0 start, 1 point, 2 penalty, 3 game over
  task automatic drive(input logic [3:0] mask);
    i_Start     = mask[0];
    i_Point     = mask[1];
    i_Penalty   = mask[2];
    i_Game_Over = mask[3];
  endtask

  // One-cycle pulse; old value must hold one edge, new value appears the next
  task automatic pulse(input logic [3:0] mask, input int s, input int h,
                       input logic nh, input logic play, input string name);
    push(1, {name, "_pre"});
    set_cur(s, h, nh, play);
    push(2, name);
    drive(mask);
    step();
    drive(4'b0000);
    step();
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Monitor: pop every expectation that is due and compare
  always @(negedge i_Clk) begin
    exp_t e;
    int   et, eo;
    while (sb_q.size() > 0 && sb_q[0].stamp <= cyc) begin
      e  = sb_q.pop_front();
      et = int'(e.score) / 10;
      eo = int'(e.score) % 10;
      n_checks++;
      if (e.stamp == cyc && o_Score == e.score && o_Tens == et && o_Ones == eo &&
          o_High_Score == e.high && o_New_High == e.nh && o_Playing == e.play) begin
        n_pass++;
      end else begin
        $display("FAIL %s cyc=%0d due=%0d: got score=%0d tens=%0d ones=%0d high=%0d nh=%0b play=%0b, want score=%0d tens=%0d ones=%0d high=%0d nh=%0b play=%0b",
                 e.name, cyc, e.stamp, o_Score, o_Tens, o_Ones, o_High_Score, o_New_High, o_Playing,
                 e.score, et, eo, e.high, e.nh, e.play);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_Rst_L = 1'b0;
    drive(4'b0000);
    set_cur(0, 0, 1'b0, 1'b0);
    step();
    push(0, "reset_init_a");
    step();
    push(0, "reset_init_b");
    i_Rst_L = 1'b1;
    step();

    // Count 12 points
    pulse(4'b0001, 0, 0, 1'b0, 1'b1, "start");
    for (int i = 1; i <= 12; i++) pulse(4'b0010, i, i, 1'b1, 1'b1, $sformatf("count_%0d", i));
    n_checks++;
    if (o_Score == 7'd12 && o_Tens == 4'd1 && o_Ones == 4'd2) begin
      n_pass++;
    end else begin
      $display("FAIL direct_count_12: score=%0d tens=%0d ones=%0d", o_Score, o_Tens, o_Ones);
    end

    // Saturation at 99, then penalties down to the floor
    for (int i = 13; i <= 117; i++)
      pulse(4'b0010, imin(i, 99), imin(i, 99), 1'b1, 1'b1, $sformatf("sat_%0d", i));
    n_checks++;
    if (o_Score == 7'd99 && o_Tens == 4'd9 && o_Ones == 4'd9) begin
      n_pass++;
    end else begin
      $display("FAIL direct_sat_99: score=%0d tens=%0d ones=%0d", o_Score, o_Tens, o_Ones);
    end
    for (int i = 98; i >= 2; i--) pulse(4'b0100, i, 99, 1'b1, 1'b1, $sformatf("pen_%0d", i));
    for (int i = 1; i <= 5; i++)
      pulse(4'b0100, (2 - i > 0) ? 2 - i : 0, 99, 1'b1, 1'b1, $sformatf("floor_%0d", i));

    // Simultaneous events at 40
    for (int i = 1; i <= 40; i++) pulse(4'b0010, i, 99, 1'b1, 1'b1, $sformatf("to40_%0d", i));
    pulse(4'b0110, 40, 99, 1'b1, 1'b1, "pt_pen_same");
    pulse(4'b1010, 41, 99, 1'b1, 1'b0, "pt_over_same");
    pulse(4'b0010, 41, 99, 1'b1, 1'b0, "pt_in_over");
    pulse(4'b0100, 41, 99, 1'b1, 1'b0, "pen_in_over");

    // Reset mid-game at 37
    pulse(4'b0001, 0, 99, 1'b0, 1'b1, "restart");
    for (int i = 1; i <= 37; i++) pulse(4'b0010, i, 99, 1'b0, 1'b1, $sformatf("to37_%0d", i));
    i_Rst_L = 1'b0;
    i_Point = 1'b1;
    set_cur(0, 0, 1'b0, 1'b0);
    push(1, "rst_mid_a");
    push(2, "rst_mid_b");
    step();
    step();
    n_checks++;
    if (o_Score == 7'd0 && o_High_Score == 7'd0 && o_Playing == 1'b0 &&
        o_New_High == 1'b0 && o_Tens == 4'd0 && o_Ones == 4'd0) begin
      n_pass++;
    end else begin
      $display("FAIL direct_rst_mid: score=%0d high=%0d play=%0b nh=%0b", o_Score, o_High_Score,
               o_Playing, o_New_High);
    end
    i_Rst_L = 1'b1;
    i_Point = 1'b0;
    step();
    pulse(4'b0010, 0, 0, 1'b0, 1'b0, "pt_no_start");

    // High score across games
    pulse(4'b0001, 0, 0, 1'b0, 1'b1, "g1_start");
    for (int i = 1; i <= 15; i++) pulse(4'b0010, i, i, 1'b1, 1'b1, $sformatf("g1_%0d", i));
    pulse(4'b1000, 15, 15, 1'b1, 1'b0, "g1_over");
    pulse(4'b0001, 0, 15, 1'b0, 1'b1, "g2_start");
    for (int i = 1; i <= 15; i++) pulse(4'b0010, i, 15, 1'b0, 1'b1, $sformatf("g2_%0d", i));
    pulse(4'b0001, 15, 15, 1'b0, 1'b1, "start_in_play");
    pulse(4'b0010, 16, 16, 1'b1, 1'b1, "g2_record");
    n_checks++;
    if (o_High_Score == 7'd16 && o_New_High == 1'b1 && o_Score == 7'd16) begin
      n_pass++;
    end else begin
      $display("FAIL direct_record: score=%0d high=%0d nh=%0b", o_Score, o_High_Score, o_New_High);
    end
    pulse(4'b1000, 16, 16, 1'b1, 1'b0, "g2_over");
    pulse(4'b0001, 0, 16, 1'b0, 1'b1, "g3_start");

    // Level input held for 50 clocks counts once
    push(1, "level_pre");
    set_cur(1, 16, 1'b0, 1'b1);
    push(2, "level_first");
    i_Point = 1'b1;
    repeat (50) step();
    push(0, "level_held");
    i_Point = 1'b0;
    step();
    step();
    push(0, "level_after");
    n_checks++;
    if (o_Score == 7'd1 && o_Tens == 4'd0 && o_Ones == 4'd1) begin
      n_pass++;
    end else begin
      $display("FAIL direct_level: score=%0d tens=%0d ones=%0d", o_Score, o_Tens, o_Ones);
    end

    // Drain scoreboard with a bounded wait
    for (int k = 0; k < 20 && sb_q.size() > 0; k++) step();
    step();
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_checks++;
      $display("FAIL %s: never compared, due=%0d now=%0d", e.name, e.stamp, cyc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
